muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Sequential multiply/divide controller and HI/LO register pair for the CPU datapath. It latches operands from the register-file read ports and drives the 64-bit signed Booth multiplier. It captures the multiplier's product into HI/LO and performs 32-bit signed division iteratively. It also services direct HI/LO writes (MTHI/MTLO), with a start/busy/done handshake to the control unit.

## Interface

Parameters:
- none; widths are fixed at 32-bit operands and a 64-bit product.

Ports:
- clk  in  1  system clock, rising-edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  operation request, sampled only while busy=0
- op  in  2  00 MUL, 01 DIV, 10 MTHI, 11 MTLO
- a  in  32  operand A / dividend / MTHI-MTLO data (signed)
- b  in  32  operand B / divisor (signed)
- mul_x  out  32  registered multiplicand to multiplier X
- mul_y  out  32  registered multiplier to multiplier Y
- mul_z  in  64  signed product from multiplier, combinational from mul_x/mul_y
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO updated on the preceding edge
- div_zero  out  1  sticky; set by DIV with b=0, cleared by the next accepted start
- hi  out  32  HI register
- lo  out  32  LO register

## Operation

- Reset (clr=0, asynchronous):
  - state=IDLE.
  - busy, done and div_zero are 0.
  - hi, lo, mul_x and mul_y are 0x00000000.
  - Internal divide registers and the counter are 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 accepts the op and clears div_zero:
  - MUL: mul_x<=a, mul_y<=b, go to MUL, busy=1.
  - DIV, b≠0: dividend magnitude |a|, divisor magnitude |b|, latch sign bits a[31] and b[31]. Remainder register <=0, count<=0. Go to DIV, busy=1.
  - DIV, b=0: hi<=a, lo<=0xFFFFFFFF, div_zero<=1, done<=1, stay IDLE; busy never rises.
  - MTHI: hi<=a, done<=1, stay IDLE. MTLO: lo<=a, done<=1, stay IDLE.
- MUL: {hi,lo}<=mul_z, done<=1, busy<=0, go to IDLE. mul_x/mul_y hold their values after completion.
- DIV: unsigned restoring shift-subtract, one quotient bit per cycle, MSB first. Each step:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor: rem -= divisor and set quo[0]=1.
  - count increments. After the 32nd step (count=31 at the edge), go to FIX.
- FIX:
  - lo <= (a_sign^b_sign) ? -quo : quo.
  - hi <= a_sign ? -rem : rem.
  - done<=1, busy<=0, go to IDLE.
  - The remainder takes the dividend's sign and the quotient truncates toward zero.
- Width rules:
  - |0x80000000| is 0x80000000 treated as unsigned.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (wraps, no flag).
- start while busy=1 is ignored, not queued. a, b and op may change freely after acceptance.
- hi/lo are unchanged except at the completion edge, or at the accept edge for MTHI/MTLO/div-by-zero.

## Timing

- done is a registered output. It is high for exactly the one cycle after the completion edge and is never high while busy=1.
- MUL: accept edge E0, completion at E1; busy high one cycle. mul_z must settle within one clock period of mul_x/mul_y changing.
- DIV: accept E0, steps at E1..E32, FIX completion at E33; busy high 33 cycles.
- MTHI/MTLO/div-by-zero: completion at the accept edge; done high the following cycle.
- Back-to-back: a start may be accepted in the same cycle that done is high (busy=0).
- clr asserted mid-operation aborts immediately to reset values. No done pulse follows.

## Test plan

- Reset then MUL: a=0xFFFFFFFD (-3), b=5, start one cycle -> busy for 1 cycle; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse of 1 cycle.
- DIV: a=0xFFFFFFF9 (-7), b=2 -> busy 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done pulse.
- DIV edge cases:
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - a=100, b=7 -> lo=14, hi=2.
  - a=5, b=0 -> same-cycle completion, hi=5, lo=0xFFFFFFFF, div_zero=1, busy never 1; next MTLO clears div_zero.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo hold those values, two done pulses, busy stays 0.
- Start pulses with op=MTHI at DIV cycles 5 and 20 -> ignored, hi unchanged until DIV completes with its correct result.
- clr pulsed low at DIV cycle 10 -> hi, lo, busy, done and div_zero all 0 immediately; no done afterward; a fresh MUL 6×7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
//   Multiply/divide controller and HI/LO register pair for the CPU datapath.
//   MUL latches the operands into mul_x/mul_y for an external combinational
//   signed multiplier and captures its 64-bit product one cycle later. DIV
//   runs a 32-step unsigned restoring divide on operand magnitudes, then
//   fixes the signs. MTHI/MTLO write HI/LO directly. Divide by zero finishes
//   at once and sets a sticky flag.
//
// Ports
//   clk       rising-edge clock
//   clr       asynchronous active-low reset
//   start     operation request, sampled only while busy=0
//   op        00 MUL, 01 DIV, 10 MTHI, 11 MTLO
//   a, b      signed operands (a is also the MTHI/MTLO data)
//   mul_x/y   registered operands to the external multiplier
//   mul_z     signed 64-bit product from the external multiplier
//   busy      operation in progress
//   done      one-cycle pulse after HI/LO have been updated
//   div_zero  sticky divide-by-zero flag, cleared by the next accepted start
//   hi, lo    HI and LO registers
module muldiv_hilo (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  count;
  logic        a_sign;
  logic        b_sign;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_neg;
  logic [31:0] rem_neg;

  // Operand magnitudes for the divider. Negating 0x80000000 wraps back to
  // 0x80000000, which is exactly the right magnitude when read as unsigned.
  // One restoring step: shift {rem, quo} left and try to subtract the divisor.
  // The 33-bit shifted remainder keeps the borrow out of the subtract visible.
  always_comb begin
    a_mag     = a[31] ? (32'd0 - a) : a;
    b_mag     = b[31] ? (32'd0 - b) : b;
    rem_shift = {rem, quo[31]};
    rem_diff  = rem_shift - {1'b0, divisor};
    rem_ge    = ~rem_diff[32];
    rem_next  = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
    quo_next  = {quo[30:0], rem_ge};
    quo_neg   = 32'd0 - quo;
    rem_neg   = 32'd0 - rem;
  end

  // Controller and all registered outputs. done defaults low each cycle so it
  // only pulses for the single cycle after a completion edge. Starts are
  // looked at only in IDLE, so requests while busy are dropped, not queued.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      mul_x    <= 32'd0;
      mul_y    <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      divisor  <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      count    <= 5'd0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            case (op)
              2'b00: begin
                mul_x <= a;
                mul_y <= b;
                busy  <= 1'b1;
                state <= S_MUL;
              end
              2'b01: begin
                if (b == 32'd0) begin
                  // Divide by zero completes on the accept edge.
                  hi       <= a;
                  lo       <= 32'hFFFF_FFFF;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  quo     <= a_mag;
                  divisor <= b_mag;
                  rem     <= 32'd0;
                  count   <= 5'd0;
                  a_sign  <= a[31];
                  b_sign  <= b[31];
                  busy    <= 1'b1;
                  state   <= S_DIV;
                end
              end
              2'b10: begin
                hi   <= a;
                done <= 1'b1;
              end
              default: begin
                lo   <= a;
                done <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          {hi, lo} <= mul_z;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= S_FIX;
          end
        end
        default: begin
          // Quotient truncates toward zero; remainder follows the dividend.
          lo    <= (a_sign ^ b_sign) ? quo_neg : quo;
          hi    <= a_sign ? rem_neg : rem;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo
//   Self-checking bench for muldiv_hilo. A behavioural signed multiplier
//   closes the mul_x/mul_y/mul_z loop. A table of directed vectors is applied
//   one operation at a time, followed by hand-written sequences for
//   back-to-back register writes, ignored starts during a divide and an
//   abort by reset in the middle of a divide.
module tb_muldiv_hilo;

  logic        clk;
  logic        clr;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic signed [63:0] x_ext;
  logic signed [63:0] y_ext;

  int compared;
  int mismatched;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[12];

  muldiv_hilo dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_z    (mul_z),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference signed multiplier: a full 64-bit signed product of the
  // registered operands.
  assign x_ext = {{32{mul_x[31]}}, mul_x};
  assign y_ext = {{32{mul_y[31]}}, mul_y};
  assign mul_z = x_ext * y_ext;

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one operation from a falling edge, scramble the inputs after the
  // accept edge, then wait (bounded) for done while counting busy cycles and
  // watching for done overlapping busy. Afterwards make sure the done pulse
  // lasted a single cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av,
                               input logic [31:0] bv, output int busy_cycles,
                               output logic saw_done, output logic overlap,
                               output logic pulse_long);
    int guard;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    a     = ~av;
    b     = bv ^ 32'h5A5A_A5A5;
    busy_cycles = 0;
    overlap     = 1'b0;
    guard       = 0;
    while (!done && guard < 100) begin
      if (busy) busy_cycles++;
      guard++;
      @(negedge clk);
    end
    saw_done = done;
    if (done && busy) overlap = 1'b1;
    @(negedge clk);
    pulse_long = done;
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic        ovl;
    logic        plong;
    int          k;
    int          guard;
    logic        hi_held;
    logic        busy_held;
    logic        late_done;

    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{"mul_neg3x5",      2'b00, 32'hFFFF_FFFD, 32'd5,
                 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1};
    vecs[1]  = '{"div_neg7by2",     2'b01, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[2]  = '{"div_min_by_neg1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vecs[3]  = '{"div_100by7",      2'b01, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0, 33};
    vecs[4]  = '{"div_by_zero",     2'b01, 32'd5, 32'd0,
                 32'd5, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[5]  = '{"mtlo_clears_dz",  2'b11, 32'hCAFE_F00D, 32'd0,
                 32'd5, 32'hCAFE_F00D, 1'b0, 0};
    vecs[6]  = '{"div_7by_neg2",    2'b01, 32'd7, 32'hFFFF_FFFE,
                 32'd1, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{"div_neg100_neg7", 2'b01, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                 32'hFFFF_FFFE, 32'd14, 1'b0, 33};
    vecs[8]  = '{"mul_min_sq",      2'b00, 32'h8000_0000, 32'h8000_0000,
                 32'h4000_0000, 32'h0000_0000, 1'b0, 1};
    vecs[9]  = '{"mul_neg1_sq",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd0, 32'd1, 1'b0, 1};
    vecs[10] = '{"mul_max_x2",      2'b00, 32'h7FFF_FFFF, 32'd2,
                 32'd0, 32'hFFFF_FFFE, 1'b0, 1};
    vecs[11] = '{"mthi",            2'b10, 32'h0BAD_BEEF, 32'd0,
                 32'h0BAD_BEEF, 32'hFFFF_FFFE, 1'b0, 0};

    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_hi",       {32'd0, hi},    64'd0);
    checkOutput("reset_lo",       {32'd0, lo},    64'd0);
    checkOutput("reset_mul_x",    {32'd0, mul_x}, 64'd0);
    checkOutput("reset_mul_y",    {32'd0, mul_y}, 64'd0);
    checkOutput("reset_busy",     {63'd0, busy},  64'd0);
    checkOutput("reset_done",     {63'd0, done},  64'd0);
    checkOutput("reset_div_zero", {63'd0, div_zero}, 64'd0);
    clr = 1'b1;

    // Directed vectors, one operation each.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc, seen, ovl, plong);
      checkOutput({vecs[i].name, "_done_seen"}, {63'd0, seen}, 64'd1);
      checkOutput({vecs[i].name, "_busy_cycles"}, 64'(cyc),
                  64'(vecs[i].exp_cycles));
      checkOutput({vecs[i].name, "_done_with_busy"}, {63'd0, ovl}, 64'd0);
      checkOutput({vecs[i].name, "_done_len"}, {63'd0, plong}, 64'd0);
      checkOutput({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      checkOutput({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      checkOutput({vecs[i].name, "_div_zero"}, {63'd0, div_zero},
                  {63'd0, vecs[i].exp_dz});
    end

    // MTHI and MTLO on consecutive cycles; the second is accepted while the
    // first one's done is still high.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'h1234_5678;
    @(negedge clk);
    checkOutput("mthi_b2b_done", {63'd0, done}, 64'd1);
    checkOutput("mthi_b2b_hi",   {32'd0, hi},   {32'd0, 32'h1234_5678});
    op = 2'b11;
    a  = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo_b2b_done", {63'd0, done}, 64'd1);
    checkOutput("mtlo_b2b_lo",   {32'd0, lo},   {32'd0, 32'h9ABC_DEF0});
    checkOutput("mtlo_b2b_hi",   {32'd0, hi},   {32'd0, 32'h1234_5678});
    checkOutput("b2b_busy",      {63'd0, busy}, 64'd0);
    @(negedge clk);
    checkOutput("b2b_done_end",  {63'd0, done}, 64'd0);

    // Stray MTHI starts during a divide must be dropped. 1000 / -9 gives
    // quotient -111 (0xFFFFFF91) and remainder 1.
    applyStimulus(2'b10, 32'h1111_1111, 32'd0, cyc, seen, ovl, plong);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'hFFFF_FFF7;
    @(negedge clk);
    start     = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'd0;
    k         = 0;
    guard     = 0;
    hi_held   = 1'b1;
    busy_held = 1'b1;
    while (!done && guard < 100) begin
      if (busy) k++;
      guard++;
      if (k == 21 && start) begin
        if (hi !== 32'h1111_1111) hi_held = 1'b0;
        if (!busy) busy_held = 1'b0;
      end
      if (k == 6 && !busy) busy_held = 1'b0;
      start = (k == 5 || k == 20);
      op    = 2'b10;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ignore_done_seen",  {63'd0, done},      64'd1);
    checkOutput("ignore_hi_held",    {63'd0, hi_held},   64'd1);
    checkOutput("ignore_busy_held",  {63'd0, busy_held}, 64'd1);
    checkOutput("ignore_busy_cycles", 64'(k), 64'd33);
    checkOutput("ignore_div_hi", {32'd0, hi}, 64'd1);
    checkOutput("ignore_div_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FF91});

    // Reset in the middle of a divide aborts it with no later done.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd50;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    clr = 1'b0;
    #1;
    checkOutput("abort_hi",       {32'd0, hi},       64'd0);
    checkOutput("abort_lo",       {32'd0, lo},       64'd0);
    checkOutput("abort_busy",     {63'd0, busy},     64'd0);
    checkOutput("abort_done",     {63'd0, done},     64'd0);
    checkOutput("abort_div_zero", {63'd0, div_zero}, 64'd0);
    checkOutput("abort_mul_x",    {32'd0, mul_x},    64'd0);
    @(negedge clk);
    clr = 1'b1;
    late_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) late_done = 1'b1;
    end
    checkOutput("abort_no_done", {63'd0, late_done}, 64'd0);

    applyStimulus(2'b00, 32'd6, 32'd7, cyc, seen, ovl, plong);
    checkOutput("post_abort_done_seen", {63'd0, seen}, 64'd1);
    checkOutput("post_abort_cycles", 64'(cyc), 64'd1);
    checkOutput("post_abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("post_abort_lo", {32'd0, lo}, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
